// File: rtl/mma7660_tilt_decoder.sv
// mma7660_tilt_decoder
// Polls the raw MMA7660 XOUT/YOUT/ZOUT registers at a fixed tick rate, drops
// samples flagged by the alert bit, block-averages the accepted samples and
// classifies board tilt through a hysteresis + debounce orientation FSM.
// Optional feature macro: TILT_SHAKE_EN (adds SHAKE_TH parameter and a shake
// output; a large sample-to-sample delta discards the current averaging block).
module mma7660_tilt_decoder #(
    parameter int SAMPLE_DIV = 120000,
    parameter int AVG_LOG2   = 2,
    parameter int TH         = 10,
    parameter int HYS        = 3,
    parameter int DEB        = 2
`ifdef TILT_SHAKE_EN
    ,
    parameter int SHAKE_TH   = 12
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] xout,
    input  logic [7:0] yout,
    input  logic [7:0] zout,
    output logic [5:0] x_avg,
    output logic [5:0] y_avg,
    output logic [5:0] z_avg,
    output logic       avg_upd,
    output logic [2:0] orient,
    output logic       orient_chg
`ifdef TILT_SHAKE_EN
    ,
    output logic       shake
`endif
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int AW    = 6 + AVG_LOG2;

    localparam logic signed [6:0] TH_P   = 7'(TH);
    localparam logic signed [6:0] TH_N   = 7'(-TH);
    localparam logic signed [6:0] HOLD_P = 7'(TH - HYS);
    localparam logic signed [6:0] HOLD_N = 7'(HYS - TH);

    typedef enum logic [2:0] {
        FLAT  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        FWD   = 3'd3,
        BACK  = 3'd4
    } orient_e;

    // Sample tick: one-cycle pulse each time the divider wraps.
    logic [DIV_W-1:0] div_reg;
    logic             tick_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (div_reg == DIV_W'(SAMPLE_DIV - 1)) begin
            div_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            div_reg  <= div_reg + 1'b1;
            tick_reg <= 1'b0;
        end
    end

    // Single input register stage in front of the sampling logic.
    logic [7:0] x_in_reg, y_in_reg, z_in_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_in_reg <= '0;
            y_in_reg <= '0;
            z_in_reg <= '0;
        end else begin
            x_in_reg <= xout;
            y_in_reg <= yout;
            z_in_reg <= zout;
        end
    end

    logic alert, sample_ok, block_drop;
    assign alert     = x_in_reg[6] | y_in_reg[6] | z_in_reg[6];
    assign sample_ok = tick_reg & ~alert;

    // Six-bit two's complement axis values, widened to accumulator width.
    logic signed [AW-1:0] x_ext, y_ext, z_ext;
    assign x_ext = {{AVG_LOG2{x_in_reg[5]}}, x_in_reg[5:0]};
    assign y_ext = {{AVG_LOG2{y_in_reg[5]}}, y_in_reg[5:0]};
    assign z_ext = {{AVG_LOG2{z_in_reg[5]}}, z_in_reg[5:0]};

    logic signed [AW-1:0] x_acc_reg, y_acc_reg, z_acc_reg;
    logic signed [AW-1:0] x_sum, y_sum, z_sum, x_shift, y_shift, z_shift;
    assign x_sum   = x_acc_reg + x_ext;
    assign y_sum   = y_acc_reg + y_ext;
    assign z_sum   = z_acc_reg + z_ext;
    assign x_shift = x_sum >>> AVG_LOG2;
    assign y_shift = y_sum >>> AVG_LOG2;
    assign z_shift = z_sum >>> AVG_LOG2;

`ifdef TILT_SHAKE_EN
    logic [5:0] x_prev_reg, y_prev_reg, z_prev_reg;
    logic       prev_vld_reg, shake_reg;

    function automatic logic [6:0] abs_delta(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] d;
        d = {a[5], a} - {b[5], b};
        return d[6] ? (~d + 7'd1) : d;
    endfunction

    assign block_drop = sample_ok & prev_vld_reg &
                        ((abs_delta(x_in_reg[5:0], x_prev_reg) >= 7'(SHAKE_TH)) |
                         (abs_delta(y_in_reg[5:0], y_prev_reg) >= 7'(SHAKE_TH)) |
                         (abs_delta(z_in_reg[5:0], z_prev_reg) >= 7'(SHAKE_TH)));

    // Remember the last accepted sample; an alert breaks the delta chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev_reg   <= '0;
            y_prev_reg   <= '0;
            z_prev_reg   <= '0;
            prev_vld_reg <= 1'b0;
            shake_reg    <= 1'b0;
        end else begin
            shake_reg <= block_drop;
            if (tick_reg) begin
                if (alert) begin
                    prev_vld_reg <= 1'b0;
                end else begin
                    x_prev_reg   <= x_in_reg[5:0];
                    y_prev_reg   <= y_in_reg[5:0];
                    z_prev_reg   <= z_in_reg[5:0];
                    prev_vld_reg <= 1'b1;
                end
            end
        end
    end
    assign shake = shake_reg;
`else
    assign block_drop = 1'b0;
`endif

    // Accumulate accepted samples; publish the floor average at block end.
    logic [AVG_LOG2-1:0] cnt_reg;
    logic [5:0]          x_avg_reg, y_avg_reg, z_avg_reg;
    logic                avg_upd_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_acc_reg   <= '0;
            y_acc_reg   <= '0;
            z_acc_reg   <= '0;
            cnt_reg     <= '0;
            x_avg_reg   <= '0;
            y_avg_reg   <= '0;
            z_avg_reg   <= '0;
            avg_upd_reg <= 1'b0;
        end else begin
            avg_upd_reg <= 1'b0;
            if (sample_ok) begin
                if (block_drop) begin
                    x_acc_reg <= '0;
                    y_acc_reg <= '0;
                    z_acc_reg <= '0;
                    cnt_reg   <= '0;
                end else if (&cnt_reg) begin
                    x_acc_reg   <= '0;
                    y_acc_reg   <= '0;
                    z_acc_reg   <= '0;
                    cnt_reg     <= '0;
                    x_avg_reg   <= x_shift[5:0];
                    y_avg_reg   <= y_shift[5:0];
                    z_avg_reg   <= z_shift[5:0];
                    avg_upd_reg <= 1'b1;
                end else begin
                    x_acc_reg <= x_sum;
                    y_acc_reg <= y_sum;
                    z_acc_reg <= z_sum;
                    cnt_reg   <= cnt_reg + 1'b1;
                end
            end
        end
    end

    orient_e state_reg, state_next;
    orient_e cand_comb, cand_reg, prev_cand_reg, prev_cand_next;
    logic    cand_vld_reg;

    // Candidate orientation from the fresh averages; hold rule gives hysteresis.
    logic signed [6:0] xs, ys;
    logic [6:0]        ax, ay;
    logic              hold;
    always_comb begin
        xs   = {x_avg_reg[5], x_avg_reg};
        ys   = {y_avg_reg[5], y_avg_reg};
        ax   = xs[6] ? 7'(-xs) : 7'(xs);
        ay   = ys[6] ? 7'(-ys) : 7'(ys);
        hold = 1'b0;
        case (state_reg)
            RIGHT:   hold = (xs >= HOLD_P);
            LEFT:    hold = (xs <= HOLD_N);
            FWD:     hold = (ys >= HOLD_P);
            BACK:    hold = (ys <= HOLD_N);
            default: hold = 1'b0;
        endcase
        cand_comb = FLAT;
        if (hold) begin
            cand_comb = state_reg;
        end else if (ax >= ay) begin
            if (xs >= TH_P)      cand_comb = RIGHT;
            else if (xs <= TH_N) cand_comb = LEFT;
        end else begin
            if (ys >= TH_P)      cand_comb = FWD;
            else if (ys <= TH_N) cand_comb = BACK;
        end
    end

    // Latch the candidate the cycle after each average update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_reg     <= FLAT;
            cand_vld_reg <= 1'b0;
        end else begin
            cand_vld_reg <= avg_upd_reg;
            if (avg_upd_reg) cand_reg <= cand_comb;
        end
    end

    // Debounce FSM state register.
    logic [3:0] deb_cnt_reg, deb_cnt_next;
    logic       orient_chg_reg, orient_chg_next;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FLAT;
            prev_cand_reg  <= FLAT;
            deb_cnt_reg    <= '0;
            orient_chg_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            prev_cand_reg  <= prev_cand_next;
            deb_cnt_reg    <= deb_cnt_next;
            orient_chg_reg <= orient_chg_next;
        end
    end

    // Debounce next-state: commit a new orientation after DEB agreeing candidates.
    logic [3:0] cnt_inc;
    always_comb begin
        state_next      = state_reg;
        prev_cand_next  = prev_cand_reg;
        deb_cnt_next    = deb_cnt_reg;
        orient_chg_next = 1'b0;
        cnt_inc         = 4'd1;
        if (cand_vld_reg) begin
            prev_cand_next = cand_reg;
            if (cand_reg == state_reg) begin
                deb_cnt_next = '0;
            end else begin
                cnt_inc = (cand_reg == prev_cand_reg) ? deb_cnt_reg + 4'd1 : 4'd1;
                if (cnt_inc >= 4'(DEB)) begin
                    state_next      = cand_reg;
                    orient_chg_next = 1'b1;
                    deb_cnt_next    = '0;
                end else begin
                    deb_cnt_next = cnt_inc;
                end
            end
        end
    end

    assign x_avg      = x_avg_reg;
    assign y_avg      = y_avg_reg;
    assign z_avg      = z_avg_reg;
    assign avg_upd    = avg_upd_reg;
    assign orient     = state_reg;
    assign orient_chg = orient_chg_reg;

endmodule

// File: tb/tb_mma7660_tilt_decoder.sv
// Testbench for mma7660_tilt_decoder: each task drives one scenario sample by
// sample and compares against a queue-based averaging/classification model.
`timescale 1ns/1ps
module tb_mma7660_tilt_decoder;

    localparam int SAMPLE_DIV = 8;
    localparam int AVG_LOG2   = 2;
    localparam int TH         = 10;
    localparam int HYS        = 3;
    localparam int DEB        = 2;
    localparam int NBLK       = 1 << AVG_LOG2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] xout = '0, yout = '0, zout = '0;
    logic [5:0] x_avg, y_avg, z_avg;
    logic       avg_upd;
    logic [2:0] orient;
    logic       orient_chg;
`ifdef TILT_SHAKE_EN
    logic       shake;
`endif

    mma7660_tilt_decoder #(
        .SAMPLE_DIV(SAMPLE_DIV),
        .AVG_LOG2  (AVG_LOG2),
        .TH        (TH),
        .HYS       (HYS),
        .DEB       (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .xout      (xout),
        .yout      (yout),
        .zout      (zout),
        .x_avg     (x_avg),
        .y_avg     (y_avg),
        .z_avg     (z_avg),
        .avg_upd   (avg_upd),
        .orient    (orient),
        .orient_chg(orient_chg)
`ifdef TILT_SHAKE_EN
        ,
        .shake     (shake)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int q_x[$], q_y[$], q_z[$];
    int m_xavg, m_yavg, m_zavg, m_orient, m_prev_cand, m_cnt;

    function automatic int dec6(input logic [7:0] v);
        int r;
        r = int'(v[5:0]);
        if (v[5]) r -= 64;
        return r;
    endfunction

    function automatic int floor_div(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clamp6(input int v);
        if (v > 31) return 31;
        if (v < -32) return -32;
        return v;
    endfunction

    function automatic logic [7:0] enc(input int v, input logic alert, input logic b7);
        logic [5:0] low;
        low = 6'(v);
        return {b7, alert, low};
    endfunction

    // Orientation codes: 0 FLAT, 1 LEFT, 2 RIGHT, 3 FWD, 4 BACK.
    function automatic int classify(input int x, input int y, input int cur);
        int h;
        h = TH - HYS;
        if (cur == 2 && x >= h)  return 2;
        if (cur == 1 && x <= -h) return 1;
        if (cur == 3 && y >= h)  return 3;
        if (cur == 4 && y <= -h) return 4;
        if (iabs(x) >= iabs(y)) begin
            if (x >= TH)  return 2;
            if (x <= -TH) return 1;
            return 0;
        end
        if (y >= TH)  return 3;
        if (y <= -TH) return 4;
        return 0;
    endfunction

    task automatic model_reset();
        q_x.delete(); q_y.delete(); q_z.delete();
        m_xavg = 0; m_yavg = 0; m_zavg = 0;
        m_orient = 0; m_prev_cand = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                              output logic e_upd, output logic e_chg);
        int sx, sy, sz, cand;
        e_upd = 1'b0;
        e_chg = 1'b0;
        if (x[6] | y[6] | z[6]) return;
        q_x.push_back(dec6(x));
        q_y.push_back(dec6(y));
        q_z.push_back(dec6(z));
        if (q_x.size() == NBLK) begin
            sx = 0; sy = 0; sz = 0;
            foreach (q_x[i]) begin
                sx += q_x[i]; sy += q_y[i]; sz += q_z[i];
            end
            m_xavg = floor_div(sx, NBLK);
            m_yavg = floor_div(sy, NBLK);
            m_zavg = floor_div(sz, NBLK);
            q_x.delete(); q_y.delete(); q_z.delete();
            e_upd = 1'b1;
            cand = classify(m_xavg, m_yavg, m_orient);
            if (cand == m_orient) begin
                m_cnt = 0;
            end else begin
                m_cnt = (cand == m_prev_cand) ? m_cnt + 1 : 1;
                if (m_cnt >= DEB) begin
                    m_orient = cand;
                    m_cnt = 0;
                    e_chg = 1'b1;
                end
            end
            m_prev_cand = cand;
        end
    endtask

    // Holds rst_n low, checks every output is cleared, then releases and
    // aligns to the middle of a sample period (ticks land at window index 4).
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        xout = 8'h0F; yout = 8'h00; zout = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (x_avg !== 6'd0) begin errors++; $display("FAIL %s x_avg got %0d want 0", tag, x_avg); end
        checks++; if (y_avg !== 6'd0) begin errors++; $display("FAIL %s y_avg got %0d want 0", tag, y_avg); end
        checks++; if (z_avg !== 6'd0) begin errors++; $display("FAIL %s z_avg got %0d want 0", tag, z_avg); end
        checks++; if (avg_upd !== 1'b0) begin errors++; $display("FAIL %s avg_upd got %b want 0", tag, avg_upd); end
        checks++; if (orient !== 3'd0) begin errors++; $display("FAIL %s orient got %0d want 0", tag, orient); end
        checks++; if (orient_chg !== 1'b0) begin errors++; $display("FAIL %s orient_chg got %b want 0", tag, orient_chg); end
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    // One sample period: present a sample, watch all strobes, compare to model.
    task automatic apply_sample(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                                input string tag);
        int upd_n, chg_n, upd_pos, chg_pos;
        logic e_upd, e_chg;
        logic [5:0] ex, ey, ez;
        logic [2:0] eo;
        upd_n = 0; chg_n = 0; upd_pos = -1; chg_pos = -1;
        xout = x; yout = y; zout = z;
        for (int i = 0; i < SAMPLE_DIV; i++) begin
            @(posedge clk);
            #1;
            if (avg_upd === 1'b1) begin upd_n++; upd_pos = i; end
            if (orient_chg === 1'b1) begin chg_n++; chg_pos = i; end
        end
        model_step(x, y, z, e_upd, e_chg);
        ex = 6'(m_xavg); ey = 6'(m_yavg); ez = 6'(m_zavg); eo = 3'(m_orient);
        checks++;
        if (upd_n !== int'(e_upd)) begin
            errors++; $display("FAIL %s avg_upd_count got %0d want %0d", tag, upd_n, e_upd);
        end
        if (e_upd && upd_n == 1) begin
            checks++;
            if (upd_pos !== 4) begin errors++; $display("FAIL %s avg_upd_phase got %0d want 4", tag, upd_pos); end
        end
        checks++;
        if (chg_n !== int'(e_chg)) begin
            errors++; $display("FAIL %s orient_chg_count got %0d want %0d", tag, chg_n, e_chg);
        end
        if (e_chg && chg_n == 1 && upd_n == 1) begin
            checks++;
            if (chg_pos !== upd_pos + 2) begin
                errors++; $display("FAIL %s orient_chg_latency got %0d want 2", tag, chg_pos - upd_pos);
            end
        end
        checks++; if (x_avg !== ex) begin errors++; $display("FAIL %s x_avg got %0d want %0d", tag, $signed(x_avg), $signed(ex)); end
        checks++; if (y_avg !== ey) begin errors++; $display("FAIL %s y_avg got %0d want %0d", tag, $signed(y_avg), $signed(ey)); end
        checks++; if (z_avg !== ez) begin errors++; $display("FAIL %s z_avg got %0d want %0d", tag, $signed(z_avg), $signed(ez)); end
        checks++; if (orient !== eo) begin errors++; $display("FAIL %s orient got %0d want %0d", tag, orient, eo); end
        $display("%s: x=%h y=%h z=%h upd=%0d chg=%0d x_avg=%0d y_avg=%0d z_avg=%0d orient=%0d",
                 tag, x, y, z, upd_n, chg_n, $signed(x_avg), $signed(y_avg), $signed(z_avg), orient);
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_right_tilt();
        for (int i = 0; i < 8; i++) apply_sample(8'h0F, 8'h02, 8'h15, "right_tilt");
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 4; i++) apply_sample(8'h08, 8'h00, 8'h15, "hyst_hold");
        for (int i = 0; i < 8; i++) apply_sample(8'h06, 8'h00, 8'h15, "hyst_release");
    endtask

    task automatic test_negative_floor();
        apply_sample(8'h3F, 8'h31, 8'h00, "neg_floor");
        apply_sample(8'h3F, 8'h31, 8'h00, "neg_floor");
        apply_sample(8'h3F, 8'h31, 8'h00, "neg_floor");
        apply_sample(8'h3E, 8'h31, 8'h00, "neg_floor");
        for (int i = 0; i < 4; i++) apply_sample(8'hBF, 8'h31, 8'h00, "neg_back");
    endtask

    task automatic test_alert();
        for (int i = 0; i < 6; i++)
            apply_sample((i == 1 || i == 4) ? 8'h4F : 8'h0F, 8'h00, 8'h00, "alert");
    endtask

    task automatic test_alternating();
        apply_reset("alt_reset");
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < NBLK; i++)
                apply_sample(b[0] ? 8'h31 : 8'h0F, 8'h00, 8'h00, "alternate");
    endtask

    task automatic test_reset_mid();
        apply_sample(8'h1F, 8'h1F, 8'h1F, "mid_pre");
        apply_sample(8'h1F, 8'h1F, 8'h1F, "mid_pre");
        apply_reset("mid_reset");
        for (int i = 0; i < NBLK; i++) apply_sample(8'h03, 8'h3D, 8'h05, "mid_post");
    endtask

    task automatic test_random();
        int bx, by, bz, len, vx, vy, vz;
        logic al;
        int which;
        for (int g = 0; g < 16; g++) begin
            bx  = int'($urandom_range(0, 50)) - 25;
            by  = int'($urandom_range(0, 50)) - 25;
            bz  = int'($urandom_range(0, 63)) - 32;
            len = int'($urandom_range(4, 12));
            for (int s = 0; s < len; s++) begin
                vx = clamp6(bx + int'($urandom_range(0, 4)) - 2);
                vy = clamp6(by + int'($urandom_range(0, 4)) - 2);
                vz = clamp6(bz + int'($urandom_range(0, 4)) - 2);
                al = ($urandom_range(0, 9) == 0);
                which = int'($urandom_range(0, 2));
                apply_sample(enc(vx, al && which == 0, 1'($urandom_range(0, 1))),
                             enc(vy, al && which == 1, 1'($urandom_range(0, 1))),
                             enc(vz, al && which == 2, 1'($urandom_range(0, 1))), "random");
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_right_tilt();
        test_hysteresis();
        test_negative_floor();
        test_alert();
        test_alternating();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mma7660_tilt_decoder.md
Name: mma7660_tilt_decoder

Overview:
- Downstream consumer of the MMA7660 accelerometer driver's xout/yout/zout registers; sits between the I2C driver and display/LED logic.
- Polls the raw 8-bit axis registers at a fixed rate and rejects samples with the alert bit set.
- Block-averages accepted samples and classifies board tilt through a hysteresis-and-debounce orientation FSM.
- Emits a stable orientation code plus averaged signed axis values with an update strobe.

Parameters:
- SAMPLE_DIV, 120000: clk cycles between sample ticks (10 ms at 12 MHz); must be >= 2.
- AVG_LOG2, 2: log2 of samples per averaging block (1..4).
- TH, 10: entry threshold in counts (about 0.47 g at 21.33 counts/g); 1..31.
- HYS, 3: hysteresis in counts, with HYS < TH.
- DEB, 2: consecutive identical candidates required before the orientation changes (1..15).

Ports:
- clk  in  1  system clock, shared with the driver.
- rst_n  in  1  asynchronous active-low reset.
- xout  in  8  raw MMA7660 XOUT register from the driver.
- yout  in  8  raw YOUT register.
- zout  in  8  raw ZOUT register.
- x_avg  out  6  signed averaged X.
- y_avg  out  6  signed averaged Y.
- z_avg  out  6  signed averaged Z.
- avg_upd  out  1  one-cycle pulse when x/y/z_avg update.
- orient  out  3  orientation code: 0 FLAT, 1 LEFT, 2 RIGHT, 3 FWD, 4 BACK.
- orient_chg  out  1  one-cycle pulse when orient changes.

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0 (orient = FLAT), tick divider 0, accumulators 0, sample count 0, debounce counter 0, candidate = FLAT. Assertion mid-block discards any partial accumulation.
- Tick generation: the divider counts 0..SAMPLE_DIV-1; tick is asserted for one cycle when it wraps.
- Input registering: inputs are registered once. On tick, the registered inputs are sampled.
- Alert rejection: if bit6 of any axis is 1, the whole sample is discarded. Nothing is accumulated and no state changes.
- Decode: value = sign-extended bits[5:0], two's complement (8'h0F = +15, 8'h31 = -15). Bit7 is ignored.
- Accumulate: accepted samples are added into signed accumulators 6+AVG_LOG2 bits wide, so overflow is impossible.
- Average output: on the 2^AVG_LOG2-th accepted sample, the cycle after the tick:
  - each avg = accumulator >>> AVG_LOG2 (arithmetic, floor);
  - avg_upd pulses;
  - accumulators and count clear.
  - Example: samples 1,1,1,2 -> 1; samples -1,-1,-1,-2 -> -2.
- Candidate evaluation: the candidate is evaluated the cycle after avg_upd.
  - Hold rule: if the current orient is non-FLAT and its own axis still satisfies the threshold TH-HYS in its own direction (RIGHT: x >= TH-HYS; LEFT: x <= -(TH-HYS); FWD: y >= TH-HYS; BACK: y <= -(TH-HYS)), candidate = current orient.
  - Otherwise, if |x| >= |y|: x >= TH -> RIGHT, x <= -TH -> LEFT, else FLAT.
  - Otherwise (|y| > |x|): y >= TH -> FWD, y <= -TH -> BACK, else FLAT.
  - |.| of -32 is 32, handled at 7-bit width.
- Debounce FSM: states track orient (FLAT, LEFT, RIGHT, FWD, BACK).
  - If candidate == orient: debounce counter clears.
  - Else if candidate equals the previous candidate: counter increments.
  - Else: counter = 1.
  - When the counter reaches DEB: orient <= candidate, orient_chg pulses, counter clears.
  - Latency from the final avg_upd to orient_chg: 2 cycles.
- Z axis: averaged and reported only; it does not affect orient.
- Static inputs: with no change at the inputs, ticks keep re-sampling the same values (the driver updates roughly every 120 ms). This is intended oversampling.

Optional Feature:
- Macro: TILT_SHAKE_EN.
- When defined:
  - adds parameter SHAKE_TH (default 12) and output port shake (1 bit);
  - on each accepted sample, compares against the previous accepted sample;
  - if |dx|, |dy| or |dz| >= SHAKE_TH, shake pulses for 1 cycle and the current averaging block is discarded (accumulators and count clear);
  - the first sample after reset or after an alert discard has no previous sample and never triggers shake.
- When undefined: no shake port and no delta logic; behaviour is exactly as above.

Test Plan:
- Simulation settings: SAMPLE_DIV=8, AVG_LOG2=2, TH=10, HYS=3, DEB=2 unless noted.
- Reset: hold rst_n=0 with xout=8'h0F -> all outputs 0, orient=0. Release -> first avg_upd only after 4 ticks.
- Right tilt: xout=8'h0F, yout=8'h02, zout=8'h15 for 8 ticks -> x_avg=15, y_avg=2, z_avg=21. orient_chg and orient=2 two cycles after the second avg_upd.
- Hysteresis: from RIGHT, x=8 -> stays RIGHT (8 >= 7). Then x=6 for two blocks -> orient=0 (FLAT).
- Negative/floor: x samples 8'h3F, 8'h3F, 8'h3F, 8'h3E -> x_avg=-2. Y=8'h31 sustained -> orient=4 (BACK).
- Alert rejection: xout=8'h4F on 2 of 6 ticks, else 8'h0F -> exactly one avg_upd, x_avg=15, no change from alert samples.
- Debounce/reset mid-op: alternate blocks x=+15 / x=-15 -> orient stays 0. Assert rst_n=0 mid-block -> partial sums discarded, next avg_upd needs 4 fresh samples.
